// File: rtl/hba_defs_pkg.sv
// Shared HBA bus definitions: arbiter FSM encodings, bus widths and master count limit.
package hba_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DBUS_WIDTH        = 8;
  localparam int PERIPH_ADDR_WIDTH = 4;
  localparam int REG_ADDR_WIDTH    = 4;
  localparam int MAX_MASTERS       = 8;

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational round-robin picker: finds the first requester above last_id, wrapping.
module hba_rr_pick
  import hba_defs::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [2:0]             last_id,
  output logic                   valid,
  output logic [2:0]             win_id,
  output logic [NUM_MASTERS-1:0] win_onehot
);

  int idx;

  // Walk from the farthest candidate down so the nearest one after last_id wins.
  always_comb begin
    valid      = 1'b0;
    win_id     = last_id;
    win_onehot = '0;
    idx        = 0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = (int'(last_id) + i) % NUM_MASTERS;
      if (req[idx]) begin
        valid  = 1'b1;
        win_id = 3'(idx);
      end
    end
    if (valid) begin
      win_onehot = NUM_MASTERS'(1) << win_id;
    end
  end

endmodule

// File: rtl/hba_arbiter.sv
// Round-robin HBA bus arbiter with hold-until-release ownership and a dead cycle between owners.
// Optional transfer watchdog enabled by defining HBA_ARBITER_TIMEOUT_EN.
module hba_arbiter
  import hba_defs::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   hba_clk,
  input  logic                   hba_reset,
  input  logic [NUM_MASTERS-1:0] hba_mrequest,
  input  logic                   hba_select,
  input  logic                   hba_xferack,
  output logic [NUM_MASTERS-1:0] hba_mgrant,
  output logic [2:0]             arb_grant_id,
  output logic                   arb_busy,
  output logic                   arb_xferack,
  output logic                   arb_timeout
);

  arb_state_t             state, next_state;
  logic [NUM_MASTERS-1:0] grant_next;
  logic [2:0]             id_next;
  logic                   pick_valid;
  logic [2:0]             pick_id;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic                   holder_req;

  hba_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req        (hba_mrequest),
    .last_id    (arb_grant_id),
    .valid      (pick_valid),
    .win_id     (pick_id),
    .win_onehot (pick_onehot)
  );

  // Select the holder's request without indexing by a wider id.
  always_comb begin
    holder_req = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (arb_grant_id == 3'(i)) holder_req = hba_mrequest[i];
    end
  end

  always_comb begin
    next_state = state;
    grant_next = hba_mgrant;
    id_next    = arb_grant_id;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_onehot;
          id_next    = pick_id;
          next_state = GRANT;
        end
      end
      GRANT: begin
        if (!holder_req) begin
          grant_next = '0;
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        grant_next = '0;
        next_state = IDLE;
      end
      default: begin
        grant_next = '0;
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      state        <= IDLE;
      hba_mgrant   <= '0;
      arb_grant_id <= 3'(NUM_MASTERS - 1);
    end else begin
      state        <= next_state;
      hba_mgrant   <= grant_next;
      arb_grant_id <= id_next;
    end
  end

  assign arb_busy = (state == GRANT);

`ifdef HBA_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_counting;

  assign wd_counting = (state == GRANT) && hba_select && !hba_xferack;

  // Forced ack is a single-cycle pulse; the grant itself is left alone.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      wd_cnt      <= '0;
      arb_xferack <= 1'b0;
      arb_timeout <= 1'b0;
    end else begin
      arb_xferack <= 1'b0;
      arb_timeout <= 1'b0;
      if (wd_counting) begin
        if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          wd_cnt      <= '0;
          arb_xferack <= 1'b1;
          arb_timeout <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  logic unused_wd_inputs;
  assign unused_wd_inputs = hba_select ^ hba_xferack;
  assign arb_xferack      = 1'b0;
  assign arb_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_hba_arbiter.sv
// Self-checking bench for hba_arbiter: directed vector table, hand sequences and a
// randomized 4-master run against a round-robin reference model.
module tb_hba_arbiter;

  localparam int T_CYC = 8;
  localparam int N2    = 4;
`ifdef HBA_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          hba_clk = 1'b0;
  logic          hba_reset;
  logic [1:0]    req1;
  logic          sel1, ack1;
  logic [1:0]    grant1;
  logic [2:0]    id1;
  logic          busy1, xack1, to1;
  logic [N2-1:0] req2;
  logic [N2-1:0] grant2;
  logic [2:0]    id2;
  logic          busy2, xack2, to2;

  int checks = 0;
  int passes = 0;

  // Reference model state for the 4-master instance: 0 idle, 1 owned, 2 dead cycle.
  int m_phase = 0;
  int m_id    = N2 - 1;

  always #5 hba_clk = ~hba_clk;

  hba_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(T_CYC)) dut (
    .hba_clk      (hba_clk),
    .hba_reset    (hba_reset),
    .hba_mrequest (req1),
    .hba_select   (sel1),
    .hba_xferack  (ack1),
    .hba_mgrant   (grant1),
    .arb_grant_id (id1),
    .arb_busy     (busy1),
    .arb_xferack  (xack1),
    .arb_timeout  (to1)
  );

  hba_arbiter #(.NUM_MASTERS(N2), .TIMEOUT_CYCLES(T_CYC)) dut4 (
    .hba_clk      (hba_clk),
    .hba_reset    (hba_reset),
    .hba_mrequest (req2),
    .hba_select   (1'b0),
    .hba_xferack  (1'b0),
    .hba_mgrant   (grant2),
    .arb_grant_id (id2),
    .arb_busy     (busy2),
    .arb_xferack  (xack2),
    .arb_timeout  (to2)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_grant;
    logic       exp_busy;
    logic [2:0] exp_id;
  } vec_t;

  vec_t vecs[19];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply_stimulus(input logic [1:0] r, input logic s, input logic a);
    req1 = r;
    sel1 = s;
    ack1 = a;
  endtask

  function automatic int rr_winner(input logic [N2-1:0] r, input int last);
    for (int i = 1; i <= N2; i++) begin
      if (r[(last + i) % N2]) return (last + i) % N2;
    end
    return -1;
  endfunction

  // Advance one clock; the model sees the same inputs the DUT sampled.
  task automatic tick();
    int w;
    @(posedge hba_clk);
    #1;
    case (m_phase)
      0: begin
        w = rr_winner(req2, m_id);
        if (w >= 0) begin
          m_id    = w;
          m_phase = 1;
        end
      end
      1: if (!req2[m_id]) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  task automatic do_reset();
    hba_reset = 1'b0;
    #12;
    hba_reset = 1'b1;
    m_phase   = 0;
    m_id      = N2 - 1;
    tick();
  endtask

  task automatic check_grant(input string name, input logic [1:0] g, input logic b, input logic [2:0] id);
    check_output({name, "_grant"}, 32'(grant1), 32'(g));
    check_output({name, "_busy"}, 32'(busy1), 32'(b));
    check_output({name, "_id"}, 32'(id1), 32'(id));
  endtask

  initial begin
    logic [1:0] own;
    logic       exp_pulse;

    vecs[0]  = '{2'b01, 2'b01, 1'b1, 3'd0};
    vecs[1]  = '{2'b01, 2'b01, 1'b1, 3'd0};
    vecs[2]  = '{2'b00, 2'b00, 1'b0, 3'd0};
    vecs[3]  = '{2'b00, 2'b00, 1'b0, 3'd0};
    vecs[4]  = '{2'b11, 2'b10, 1'b1, 3'd1};
    vecs[5]  = '{2'b11, 2'b10, 1'b1, 3'd1};
    vecs[6]  = '{2'b01, 2'b00, 1'b0, 3'd1};
    vecs[7]  = '{2'b01, 2'b00, 1'b0, 3'd1};
    vecs[8]  = '{2'b01, 2'b01, 1'b1, 3'd0};
    vecs[9]  = '{2'b11, 2'b01, 1'b1, 3'd0};
    vecs[10] = '{2'b10, 2'b00, 1'b0, 3'd0};
    vecs[11] = '{2'b10, 2'b00, 1'b0, 3'd0};
    vecs[12] = '{2'b10, 2'b10, 1'b1, 3'd1};
    vecs[13] = '{2'b00, 2'b00, 1'b0, 3'd1};
    vecs[14] = '{2'b10, 2'b00, 1'b0, 3'd1};
    vecs[15] = '{2'b00, 2'b00, 1'b0, 3'd1};
    vecs[16] = '{2'b01, 2'b01, 1'b1, 3'd0};
    vecs[17] = '{2'b00, 2'b00, 1'b0, 3'd0};
    vecs[18] = '{2'b00, 2'b00, 1'b0, 3'd0};

    apply_stimulus(2'b00, 1'b0, 1'b0);
    req2 = '0;
    do_reset();
    check_grant("reset", 2'b00, 1'b0, 3'd1);
    check_output("reset_xferack", 32'(xack1), 32'd0);
    check_output("reset_timeout", 32'(to1), 32'd0);
    check_output("reset4_id", 32'(id2), 32'd3);

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].req, 1'b0, 1'b0);
      tick();
      check_grant($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_busy, vecs[i].exp_id);
    end

    // Alternating ownership, each owner drops 4 cycles after its grant.
    do_reset();
    for (int g = 0; g < 3; g++) begin
      own = (g % 2 == 0) ? 2'b01 : 2'b10;
      for (int c = 0; c < 4; c++) begin
        apply_stimulus(2'b11, 1'b0, 1'b0);
        tick();
        check_grant($sformatf("alt%0d_hold%0d", g, c), own, 1'b1, 3'(g % 2));
      end
      apply_stimulus(~own, 1'b0, 1'b0);
      tick();
      check_output($sformatf("alt%0d_gap0", g), 32'(grant1), 32'd0);
      apply_stimulus(2'b11, 1'b0, 1'b0);
      tick();
      check_output($sformatf("alt%0d_gap1", g), 32'(grant1), 32'd0);
    end

    // Master 1 owns, master 0 asks mid-grant and must wait for the drop.
    apply_stimulus(2'b10, 1'b0, 1'b0);
    tick();
    check_grant("hold1_start", 2'b10, 1'b1, 3'd1);
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(2'b11, 1'b0, 1'b0);
      tick();
      check_grant($sformatf("hold1_nopreempt%0d", c), 2'b10, 1'b1, 3'd1);
    end
    apply_stimulus(2'b01, 1'b0, 1'b0);
    tick();
    check_output("hold1_drop", 32'(grant1), 32'd0);
    tick();
    check_output("hold1_dead", 32'(grant1), 32'd0);
    tick();
    check_grant("hold1_m0", 2'b01, 1'b1, 3'd0);

    // Asynchronous reset while master 1 holds the bus.
    apply_stimulus(2'b00, 1'b0, 1'b0);
    tick();
    tick();
    apply_stimulus(2'b10, 1'b0, 1'b0);
    tick();
    check_grant("pre_areset", 2'b10, 1'b1, 3'd1);
    #3;
    hba_reset = 1'b0;
    #1;
    check_grant("areset", 2'b00, 1'b0, 3'd1);
    apply_stimulus(2'b11, 1'b0, 1'b0);
    hba_reset = 1'b1;
    m_phase   = 0;
    m_id      = N2 - 1;
    tick();
    check_grant("after_areset", 2'b01, 1'b1, 3'd0);

    // Watchdog: select without ack, pulses expected every T_CYC cycles when enabled.
    for (int n = 1; n <= 20; n++) begin
      apply_stimulus(2'b11, 1'b1, 1'b0);
      tick();
      exp_pulse = TO_EN && (n == T_CYC || n == 2 * T_CYC);
      check_output($sformatf("wd_timeout_c%0d", n), 32'(to1), 32'(exp_pulse));
      check_output($sformatf("wd_xferack_c%0d", n), 32'(xack1), 32'(exp_pulse));
    end
    check_output("wd_grant_kept", 32'(grant1), 32'b01);
    apply_stimulus(2'b11, 1'b0, 1'b0);
    tick();
    check_output("wd_idle_sel", 32'(to1), 32'd0);
    for (int n = 1; n <= 12; n++) begin
      apply_stimulus(2'b11, 1'b1, (n == 5));
      tick();
      check_output($sformatf("wd_ack_timeout_c%0d", n), 32'(to1), 32'd0);
      check_output($sformatf("wd_ack_xferack_c%0d", n), 32'(xack1), 32'd0);
    end
    apply_stimulus(2'b00, 1'b0, 1'b0);
    tick();
    tick();

    // Randomized 4-master run against the reference model.
    for (int c = 0; c < 300; c++) begin
      req2 = 4'($urandom_range(0, 15));
      tick();
      check_output($sformatf("rnd%0d_grant", c), 32'(grant2),
                   (m_phase == 1) ? (32'd1 << m_id) : 32'd0);
      check_output($sformatf("rnd%0d_busy", c), 32'(busy2), 32'(m_phase == 1));
      check_output($sformatf("rnd%0d_id", c), 32'(id2), 32'(m_id));
      check_output($sformatf("rnd%0d_to", c), 32'({xack2, to2}), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hba_arbiter.md
# hba_arbiter

Round-robin bus arbiter for the HBA bus. It sits between the HBA masters (serial_fpga and any later masters) and the shared slave bus, and replaces the hard-wired grant currently tied off in top-level test designs. It accepts one request line per master and issues exactly one one-hot grant. Ownership is held until the owning master drops its request. An optional watchdog terminates transfers that no slave acknowledges.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting masters (legal range 2..8)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (only used with HBA_ARBITER_TIMEOUT_EN; legal range 1..65535)

Ports:
- hba_clk  input  1  single clock for the whole block
- hba_reset  input  1  asynchronous, active-low reset
- hba_mrequest  input  NUM_MASTERS  per-master bus request, level-sensitive
- hba_select  input  1  bus transfer in progress (OR of all master selects)
- hba_xferack  input  1  slave acknowledge (OR of all slave acks)
- hba_mgrant  output  NUM_MASTERS  one-hot grant, registered
- arb_grant_id  output  3  index of current/last granted master, registered
- arb_busy  output  1  high while in GRANT state
- arb_xferack  output  1  watchdog-forced acknowledge; ORed onto hba_xferack at top level
- arb_timeout  output  1  one-cycle pulse when watchdog fires

## Operation
- Reset values: hba_mgrant=0, arb_grant_id=NUM_MASTERS-1, arb_busy=0, arb_xferack=0, arb_timeout=0, state=IDLE.
- Because the pointer resets to NUM_MASTERS-1, master 0 wins the first arbitration.
- FSM states:
  - IDLE: if any request, load the winner's one-hot grant and id, go to GRANT; else stay.
  - GRANT: hold the grant while hba_mrequest[arb_grant_id]=1; when it samples 0, clear grant and go to RELEASE.
  - RELEASE: grant stays 0 for one dead cycle, so the old master's bus outputs return to zero; go to IDLE.
- Winner: the first requesting index searching upward from arb_grant_id+1, wrapping modulo NUM_MASTERS. The current holder has lowest priority in the next arbitration.
- hba_mgrant is never more than one-hot, including during reset release.
- Requests from other masters during GRANT are ignored; no preemption.
- A request that drops in the same cycle it is sampled in IDLE is still granted. The grant is then released through GRANT->RELEASE on the next edge.
- Request bits at or above NUM_MASTERS do not exist; the width is exact.

## Timing
- Request first sampled high at edge k in IDLE -> hba_mgrant valid after edge k (1-cycle latency).
- Holder drops its request, sampled at edge k -> grant low after edge k, RELEASE during k..k+1, IDLE after k+1. The earliest next grant is after edge k+2.
- Back-to-back handover, master 0 to master 1, gives 2 cycles with no grant.
- Asserting reset at any time, including mid-transfer, clears the grant asynchronously. Deassertion is synchronised by the system reset logic upstream.

## Configuration
- Macro: HBA_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments in GRANT while hba_select=1 and hba_xferack=0.
  - The counter clears on xferack, on hba_select=0, or outside GRANT.
  - On reaching TIMEOUT_CYCLES, arb_xferack and arb_timeout pulse high for exactly one cycle and the counter clears. The grant is not revoked.
- When undefined: arb_xferack and arb_timeout are constant 0, no counter is built, and TIMEOUT_CYCLES is ignored.

## Structure
- Shared package/header hba_defs holds:
  - FSM state encodings: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2.
  - HBA bus width constants: DBUS_WIDTH, PERIPH_ADDR_WIDTH, REG_ADDR_WIDTH.
  - Max master count, 8.
- One sub-module, hba_rr_pick: combinational round-robin picker (inputs: request vector, last id; outputs: valid, winner id, one-hot). Top holds the FSM, registers and watchdog.

## Test plan
- Reset, then hba_mrequest=2'b01 -> hba_mgrant=2'b01 one cycle later, arb_busy=1, arb_grant_id=0.
- Both masters request continuously, each dropping its request 4 cycles after grant -> grants alternate 01,10,01 with a 2-cycle gap between them.
- Master 1 holds its grant; master 0 requests mid-grant -> no change until master 1 drops; master 0 is granted 2 cycles after the drop.
- Reset asserted while hba_mgrant=2'b10 -> grant 0 immediately with no clock; after release with request 2'b11, master 0 wins.
- With HBA_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant held, hba_select=1, no ack -> arb_xferack and arb_timeout pulse once at 8 cycles, then again 8 cycles later; an ack at cycle 5 prevents the pulse.
- Without the macro, same stimulus -> arb_xferack and arb_timeout remain 0 throughout.
